// File: rtl/whiten_sequencer_pkg.sv
// Shared types for the whitening-stage sequencer: FSM states and memory-owner codes.
package whiten_sequencer_pkg;

   typedef enum logic [2:0] {
      StIdle,
      StCov,
      StEvd,
      StWht,
      StDone,
      StFail
   } state_e;

   // Sample-memory read owner; also used to report which stage timed out.
   typedef logic [1:0] sel_t;

   localparam sel_t SelNone = 2'd0;
   localparam sel_t SelCov  = 2'd1;
   localparam sel_t SelEvd  = 2'd2;
   localparam sel_t SelWht  = 2'd3;

   // Memory owner implied by a state; only the three run stages own the memory.
   function automatic sel_t state_sel(state_e st);
      sel_t sel;
      case (st)
         StCov:   sel = SelCov;
         StEvd:   sel = SelEvd;
         StWht:   sel = SelWht;
         default: sel = SelNone;
      endcase
      return sel;
   endfunction

endpackage

// File: rtl/whiten_sequencer_if.sv
// Host and sub-controller handshake bundle for the whitening sequencer.
interface whiten_sequencer_if;
   import whiten_sequencer_pkg::*;

   logic start;
   logic abort;
   logic cov_busy;
   logic evd_busy;
   logic wht_busy;
   logic cov_go;
   logic evd_go;
   logic wht_go;
   sel_t mem_sel;
   logic busy;
   logic done;
   logic err;
   sel_t err_stg;

   modport master (
      output start, abort, cov_busy, evd_busy, wht_busy,
      input  cov_go, evd_go, wht_go, mem_sel, busy, done, err, err_stg
   );

   modport slave (
      input  start, abort, cov_busy, evd_busy, wht_busy,
      output cov_go, evd_go, wht_go, mem_sel, busy, done, err, err_stg
   );

endinterface

// File: rtl/whiten_sequencer_stage_watchdog.sv
// Per-stage watchdog shared by all stages: saturating cycle counter with a blanking
// window (busy ignored) and a timeout compare.
module whiten_sequencer_stage_watchdog #(
   parameter int unsigned BlankCyc = 2,
   parameter int unsigned TmoCyc   = 1024,
   parameter int unsigned CntW     = 11
) (
   input  logic clk_i,
   input  logic rst_ni,
   input  logic clr_i,
   input  logic busy_i,
   output logic done_ok_o,
   output logic tmo_o
);

   localparam logic [CntW-1:0] WdogMax = '1;
   localparam logic [CntW-1:0] Blank   = CntW'(BlankCyc);
   localparam logic [CntW-1:0] Tmo     = CntW'(TmoCyc);

   logic [CntW-1:0] wdog_q, wdog_d;

   // Clear on stage change, otherwise count up and hold at all-ones.
   always_comb begin
      wdog_d = wdog_q;
      if (clr_i) begin
         wdog_d = '0;
      end else if (wdog_q != WdogMax) begin
         wdog_d = wdog_q + CntW'(1);
      end
   end

   // Counter register.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         wdog_q <= '0;
      end else begin
         wdog_q <= wdog_d;
      end
   end

   // Busy is only trusted once the blanking window has elapsed.
   assign done_ok_o = (wdog_q >= Blank) && !busy_i;
   assign tmo_o     = (wdog_q == Tmo) && busy_i;

endmodule

// File: rtl/whiten_sequencer.sv
// Whitening-stage sequencer: runs covariance, eigen-decomposition and whitening multiply
// in order, owns the sample-memory read select and reports DONE or a sticky timeout.
module whiten_sequencer #(
   parameter int unsigned BlankCyc = 2,
   parameter int unsigned TmoCyc   = 1024,
   parameter int unsigned CntW     = 11
) (
   input logic              clk_i,
   input logic              rst_ni,
   whiten_sequencer_if.slave bus_io
);
   import whiten_sequencer_pkg::*;

   state_e     state_q, state_d;
   logic       start_q;
   logic       rise;
   logic       stg_busy;
   logic       done_ok;
   logic       tmo;
   logic       wd_clr;
   logic [2:0] go_q, go_d;
   sel_t       sel_q, sel_d;
   logic       busy_q, busy_d;
   logic       done_q, done_d;
   logic       err_q, err_d;
   sel_t       err_stg_q, err_stg_d;

   assign rise   = bus_io.start & ~start_q;
   // Every state change restarts the watchdog, so each stage starts counting from zero.
   assign wd_clr = (state_d != state_q);

   // Route the active stage's busy to the shared watchdog.
   always_comb begin
      stg_busy = 1'b0;
      case (state_q)
         StCov:   stg_busy = bus_io.cov_busy;
         StEvd:   stg_busy = bus_io.evd_busy;
         StWht:   stg_busy = bus_io.wht_busy;
         default: stg_busy = 1'b0;
      endcase
   end

   whiten_sequencer_stage_watchdog #(
      .BlankCyc(BlankCyc),
      .TmoCyc  (TmoCyc),
      .CntW    (CntW)
   ) u_wdog (
      .clk_i    (clk_i),
      .rst_ni   (rst_ni),
      .clr_i    (wd_clr),
      .busy_i   (stg_busy),
      .done_ok_o(done_ok),
      .tmo_o    (tmo)
   );

   // State and start-edge registers.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= StIdle;
         start_q <= 1'b0;
      end else begin
         state_q <= state_d;
         start_q <= bus_io.start;
      end
   end

   // Next state; abort beats everything, stage exit beats timeout.
   always_comb begin
      state_d = state_q;
      if (bus_io.abort) begin
         state_d = StIdle;
      end else begin
         case (state_q)
            StIdle: if (rise) state_d = StCov;
            StCov: begin
               if (done_ok)  state_d = StEvd;
               else if (tmo) state_d = StFail;
            end
            StEvd: begin
               if (done_ok)  state_d = StWht;
               else if (tmo) state_d = StFail;
            end
            StWht: begin
               if (done_ok)  state_d = StDone;
               else if (tmo) state_d = StFail;
            end
            StDone:  state_d = StIdle;
            StFail:  state_d = StIdle;
            default: state_d = StIdle;
         endcase
      end
   end

   // Outputs decoded from the next state so they register alongside it.
   always_comb begin
      go_d      = 3'b000;
      sel_d     = state_sel(state_d);
      busy_d    = 1'b0;
      done_d    = 1'b0;
      err_d     = err_q;
      err_stg_d = err_stg_q;
      case (state_d)
         StCov: begin
            go_d   = 3'b100;
            busy_d = 1'b1;
            // Launching a pass is the only thing that clears the sticky error.
            if (state_q != StCov) begin
               err_d     = 1'b0;
               err_stg_d = SelNone;
            end
         end
         // Earlier stages keep their GO high so their results stay held.
         StEvd: begin
            go_d   = 3'b110;
            busy_d = 1'b1;
         end
         StWht: begin
            go_d   = 3'b111;
            busy_d = 1'b1;
         end
         StDone: done_d = 1'b1;
         StFail: begin
            err_d     = 1'b1;
            err_stg_d = sel_q;
         end
         default: ;
      endcase
   end

   // Output registers.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         go_q      <= 3'b000;
         sel_q     <= SelNone;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         err_q     <= 1'b0;
         err_stg_q <= SelNone;
      end else begin
         go_q      <= go_d;
         sel_q     <= sel_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
         err_q     <= err_d;
         err_stg_q <= err_stg_d;
      end
   end

   assign bus_io.cov_go  = go_q[2];
   assign bus_io.evd_go  = go_q[1];
   assign bus_io.wht_go  = go_q[0];
   assign bus_io.mem_sel = sel_q;
   assign bus_io.busy    = busy_q;
   assign bus_io.done    = done_q;
   assign bus_io.err     = err_q;
   assign bus_io.err_stg = err_stg_q;

endmodule
